tsmp_input_arbiter: RTL and testbench
=====================================

# tsmp_input_arbiter

Round-robin arbiter that shares the single TSMP frame-encapsulation datapath between three frame sources: ARP request, PTP, and NMAC report. Each source requests the path, receives a one-hot grant, and streams one complete 134-bit-word frame. The arbiter forwards the granted frame with a fixed 1-cycle latency. After each frame it enforces an idle gap so the encapsulator can return to its idle state, and it force-closes frames that stall or are malformed.

## Interface
Parameters:
- GAP_CYCLES, 2, idle cycles inserted after each forwarded tail before the next grant (0 allowed).
- TIMEOUT_CYCLES, 64, consecutive cycles without an accepted write from the granted source before abort (1..255).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- iv_req  in  3  per-source request; bit0 ARP, bit1 PTP, bit2 NMAC.
- ov_grant  out  3  one-hot grant, registered.
- iv_data0 / iv_data1 / iv_data2  in  134  source frame words; [133:132]: 01 head, 11 middle, 10 tail; [131:128] tail invalid-byte count.
- i_data0_wr / i_data1_wr / i_data2_wr  in  1  word valid per source.
- iv_inport0 / iv_inport1 / iv_inport2  in  4  ingress port of the source frame.
- ov_data  out  134  forwarded word to the encapsulator.
- o_data_wr  out  1  forwarded word valid.
- ov_inport  out  4  inport of the granted source, held for the whole frame.
- ov_abort_cnt  out  16  saturating count of aborted frames.

## Operation
- States: IDLE, WAIT_HEAD, TRANS, GAP.
- IDLE, any iv_req bit set:
  - Choose the first requesting source after the last winner, in order 0→1→2→0.
  - The last-winner pointer resets to 2, so port 0 wins first after reset.
  - Set ov_grant, latch ov_inport, update the pointer, go to WAIT_HEAD.
- WAIT_HEAD:
  - Only the granted source's wr is observed; wr on other sources is ignored.
  - Granted wr with head type: forward the word, go to TRANS.
  - Granted wr with middle or tail type: drop the word, stay, reset the watchdog.
  - Granted iv_req deasserted before a head arrives: clear the grant, go to IDLE, no abort counted.
- TRANS:
  - Middle word: forward it.
  - Tail word: forward it, clear ov_grant, go to GAP (or IDLE if GAP_CYCLES=0).
  - Head word (new frame inside a frame): do not forward it. Emit a forced tail {2'b10,4'h0,128'h0} with o_data_wr=1, increment ov_abort_cnt, clear the grant, go to GAP.
  - iv_req is ignored in TRANS; the frame must finish.
- Watchdog:
  - Counts cycles in WAIT_HEAD/TRANS with no granted wr; reloads to 0 on each granted wr.
  - Timeout in WAIT_HEAD: clear the grant, increment the abort count, go to IDLE, emit nothing.
  - Timeout in TRANS: emit a forced tail as above, increment the abort count, go to GAP.
- GAP: count GAP_CYCLES cycles with o_data_wr=0, then go to IDLE. Requests are held off until then.
- ov_abort_cnt saturates at 16'hFFFF.
- Forwarded words are copied unmodified, including [131:128]. When o_data_wr=0, ov_data is 0.

## Timing
- Reset values: ov_grant=0, ov_data=0, o_data_wr=0, ov_inport=0, ov_abort_cnt=0, state IDLE, pointer=2, watchdog=0, gap counter=0.
- Reset mid-frame clears everything immediately. No tail is emitted; downstream is reset by the same i_rst.
- Request sampled in IDLE at edge k → ov_grant visible after edge k. The source may present its head from the cycle after edge k.
- Data latency: granted word at edge n → ov_data/o_data_wr valid after edge n (exactly 1 register stage).
- Tail accepted at edge t → ov_grant=0 after edge t. With GAP_CYCLES=G, the earliest next grant is after edge t+G+1.
- Timeout fires on the edge where the count reaches TIMEOUT_CYCLES. The forced tail appears after that edge.
- Simultaneous requests: resolved only by the round-robin pointer; no fixed priority.
- A request that arrives during TRANS/GAP is served in the next IDLE.

## Test plan
- Single ARP frame: req=001, 4-word frame (01,11,11,10 tail nibble 4'h6) → grant=001 the next cycle; 4 words out, each 1 cycle late, bit-identical; grant drops on the tail; 2 idle cycles follow.
- Fairness: iv_req=111 held, each source sends 2-word frames → grant order 001,010,100,001; each grant is separated by ≥GAP_CYCLES+1 idle output cycles.
- Stall in TRANS: granted PTP sends its head then stops for 64 cycles → forced tail {2'b10,4'h0,0} emitted; ov_abort_cnt=1; next request served after the gap.
- Head inside frame: granted NMAC sends 01,11,01 → two words forwarded, then a forced tail in place of the second head; ov_abort_cnt increments; the second head is not forwarded.
- Deassert before head: req=010, granted, req drops with no wr → grant clears, back to IDLE, ov_abort_cnt unchanged; non-granted wr on ports 0/2 during the grant is never forwarded.
- Reset mid-frame: assert i_rst during the second word → all outputs 0 asynchronously; after release, req=111 → port 0 is granted first.

Source files
------------

// File: rtl/tsmp_input_arbiter.sv
// tsmp_input_arbiter
// Round-robin arbiter that lets three frame sources (ARP request, PTP, NMAC
// report) share one TSMP encapsulation datapath. The granted source streams
// a complete frame, which is forwarded with a single register stage. After
// each frame an idle gap lets the encapsulator return to idle. Stalled or
// malformed frames are closed with a forced tail and counted.

module tsmp_input_arbiter #(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [2:0]   iv_req,
  output logic [2:0]   ov_grant,
  input  logic [133:0] iv_data0,
  input  logic [133:0] iv_data1,
  input  logic [133:0] iv_data2,
  input  logic         i_data0_wr,
  input  logic         i_data1_wr,
  input  logic         i_data2_wr,
  input  logic [3:0]   iv_inport0,
  input  logic [3:0]   iv_inport1,
  input  logic [3:0]   iv_inport2,
  output logic [133:0] ov_data,
  output logic         o_data_wr,
  output logic [3:0]   ov_inport,
  output logic [15:0]  ov_abort_cnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HEAD = 2'd1,
    TRANS     = 2'd2,
    GAP       = 2'd3
  } state_t;

  // Word type lives in the top two bits of every frame word.
  localparam logic [1:0] TYPE_HEAD = 2'b01;
  localparam logic [1:0] TYPE_MID  = 2'b11;
  localparam logic [1:0] TYPE_TAIL = 2'b10;

  // Tail word used to close a frame the source failed to finish cleanly.
  localparam logic [133:0] FORCED_TAIL = {TYPE_TAIL, 4'h0, 128'h0};

  localparam logic [7:0]  TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);
  localparam logic [15:0] GAP_LAST    = 16'(GAP_CYCLES - 1);
  localparam state_t      AFTER_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

  // Registered state
  state_t         state_q,  state_d;
  logic [2:0]     grant_q,  grant_d;
  logic [3:0]     inport_q, inport_d;
  logic [1:0]     ptr_q,    ptr_d;     // index of the last winner
  logic [7:0]     wdog_q,   wdog_d;
  logic [15:0]    gap_q,    gap_d;
  logic [133:0]   data_q,   data_d;
  logic           wr_q,     wr_d;
  logic [15:0]    abort_q;
  logic           abort_inc;

  // Granted-source view and arbitration result
  logic           sel_wr;
  logic           sel_req;
  logic [133:0]   sel_data;
  logic [1:0]     win_idx;
  logic [3:0]     win_inport;
  logic [7:0]     wdog_inc;
  logic           wdog_expired;

  // Steer the granted source onto a single word/valid/request view.
  always_comb begin
    sel_wr   = |(grant_q & {i_data2_wr, i_data1_wr, i_data0_wr});
    sel_req  = |(grant_q & iv_req);
    sel_data = ({134{grant_q[0]}} & iv_data0)
             | ({134{grant_q[1]}} & iv_data1)
             | ({134{grant_q[2]}} & iv_data2);
  end

  // Round-robin pick: first requester after the last winner, order 0->1->2->0.
  always_comb begin
    win_idx = 2'd0;
    unique case (ptr_q)
      2'd0: begin
        if      (iv_req[1]) win_idx = 2'd1;
        else if (iv_req[2]) win_idx = 2'd2;
        else                win_idx = 2'd0;
      end
      2'd1: begin
        if      (iv_req[2]) win_idx = 2'd2;
        else if (iv_req[0]) win_idx = 2'd0;
        else                win_idx = 2'd1;
      end
      default: begin
        if      (iv_req[0]) win_idx = 2'd0;
        else if (iv_req[1]) win_idx = 2'd1;
        else                win_idx = 2'd2;
      end
    endcase
    unique case (win_idx)
      2'd0:    win_inport = iv_inport0;
      2'd1:    win_inport = iv_inport1;
      default: win_inport = iv_inport2;
    endcase
  end

  // Next-state, grant, watchdog, gap and forwarded-word logic.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    grant_d      = grant_q;
    inport_d     = inport_q;
    ptr_d        = ptr_q;
    wdog_d       = wdog_q;
    gap_d        = gap_q;
    data_d       = '0;
    wr_d         = 1'b0;
    abort_inc    = 1'b0;
    wdog_inc     = wdog_q + 8'd1;
    wdog_expired = (wdog_inc == TIMEOUT_LIM);

    unique case (state_q)
      IDLE: begin
        if (|iv_req) begin
          grant_d  = 3'(3'b001 << win_idx);
          inport_d = win_inport;
          ptr_d    = win_idx;
          wdog_d   = '0;
          state_d  = WAIT_HEAD;
        end
      end

      WAIT_HEAD: begin
        if (sel_wr && sel_data[133:132] == TYPE_HEAD) begin
          data_d  = sel_data;
          wr_d    = 1'b1;
          wdog_d  = '0;
          state_d = TRANS;
        end else if (!sel_req) begin
          // Source withdrew before starting; nothing was sent, not an abort.
          grant_d = '0;
          wdog_d  = '0;
          state_d = IDLE;
        end else if (sel_wr) begin
          // Stray middle/tail before a head: drop it, source is still alive.
          wdog_d = '0;
        end else if (wdog_expired) begin
          grant_d   = '0;
          wdog_d    = '0;
          abort_inc = 1'b1;
          state_d   = IDLE;
        end else begin
          wdog_d = wdog_inc;
        end
      end

      TRANS: begin
        if (sel_wr) begin
          wdog_d = '0;
          if (sel_data[133:132] == TYPE_MID) begin
            data_d = sel_data;
            wr_d   = 1'b1;
          end else if (sel_data[133:132] == TYPE_TAIL) begin
            data_d  = sel_data;
            wr_d    = 1'b1;
            grant_d = '0;
            gap_d   = '0;
            state_d = AFTER_FRAME;
          end else begin
            // A head (or invalid type) inside a frame: close the open frame.
            data_d    = FORCED_TAIL;
            wr_d      = 1'b1;
            grant_d   = '0;
            gap_d     = '0;
            abort_inc = 1'b1;
            state_d   = AFTER_FRAME;
          end
        end else if (wdog_expired) begin
          data_d    = FORCED_TAIL;
          wr_d      = 1'b1;
          grant_d   = '0;
          wdog_d    = '0;
          gap_d     = '0;
          abort_inc = 1'b1;
          state_d   = AFTER_FRAME;
        end else begin
          wdog_d = wdog_inc;
        end
      end

      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register and output stage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      inport_q <= '0;
      ptr_q    <= 2'd2;
      wdog_q   <= '0;
      gap_q    <= '0;
      data_q   <= '0;
      wr_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q  <= state_d;
      grant_q  <= grant_d;
      inport_q <= inport_d;
      ptr_q    <= ptr_d;
      wdog_q   <= wdog_d;
      gap_q    <= gap_d;
      data_q   <= data_d;
      wr_q     <= wr_d;
    end
  end

  // Saturating count of aborted frames.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      abort_q <= '0;
    end else if (abort_inc && abort_q != 16'hFFFF) begin
      abort_q <= abort_q + 16'd1;
    end
  end

  assign ov_grant     = grant_q;
  assign ov_inport    = inport_q;
  assign ov_data      = data_q;
  assign o_data_wr    = wr_q;
  assign ov_abort_cnt = abort_q;

endmodule

// File: tb/tb_tsmp_input_arbiter.sv
// Self-checking bench for tsmp_input_arbiter. Expected output words are
// queued when a source drives them and popped when o_data_wr is seen.

module tb_tsmp_input_arbiter;

  localparam int G  = 2;
  localparam int TO = 64;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic [2:0]   iv_req = '0;
  logic [2:0]   ov_grant;
  logic [133:0] iv_data0 = '0, iv_data1 = '0, iv_data2 = '0;
  logic         i_data0_wr = 1'b0, i_data1_wr = 1'b0, i_data2_wr = 1'b0;
  logic [3:0]   iv_inport0 = 4'h3, iv_inport1 = 4'h5, iv_inport2 = 4'h9;
  logic [133:0] ov_data;
  logic         o_data_wr;
  logic [3:0]   ov_inport;
  logic [15:0]  ov_abort_cnt;

  localparam logic [133:0] FORCED = {2'b10, 4'h0, 128'h0};

  tsmp_input_arbiter #(.GAP_CYCLES(G), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .iv_req       (iv_req),
    .ov_grant     (ov_grant),
    .iv_data0     (iv_data0),
    .iv_data1     (iv_data1),
    .iv_data2     (iv_data2),
    .i_data0_wr   (i_data0_wr),
    .i_data1_wr   (i_data1_wr),
    .i_data2_wr   (i_data2_wr),
    .iv_inport0   (iv_inport0),
    .iv_inport1   (iv_inport1),
    .iv_inport2   (iv_inport2),
    .ov_data      (ov_data),
    .o_data_wr    (o_data_wr),
    .ov_inport    (ov_inport),
    .ov_abort_cnt (ov_abort_cnt)
  );

  always #5 i_clk = ~i_clk;

  logic [133:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [133:0] got, input logic [133:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge i_clk) begin
    logic [133:0] e;
    if (!i_rst) begin
      if (o_data_wr) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_wr", 134'(o_data_wr), 134'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", ov_data, e);
        end
      end else begin
        check("idle_data_zero", ov_data, 134'd0);
      end
    end
  end

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [133:0] mk(input logic [1:0] t, input logic [3:0] nib);
    return {t, nib, $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drive(input int p, input logic [133:0] w, input bit fwd);
    case (p)
      0: begin iv_data0 = w; i_data0_wr = 1'b1; end
      1: begin iv_data1 = w; i_data1_wr = 1'b1; end
      default: begin iv_data2 = w; i_data2_wr = 1'b1; end
    endcase
    if (fwd) exp_q.push_back(w);
    cyc();
    i_data0_wr = 1'b0;
    i_data1_wr = 1'b0;
    i_data2_wr = 1'b0;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (ov_grant == 3'b000 && n < 200) begin
      cyc();
      n++;
    end
    if (ov_grant == 3'b000) check("grant_wait_timeout", 134'(n), 134'd0);
  endtask

  logic [2:0] fair_exp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  int         fair_port [4] = '{0, 1, 2, 0};

  initial begin
    int n;

    // Reset state
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    check("rst_grant", 134'(ov_grant), 134'd0);
    check("rst_data", ov_data, 134'd0);
    check("rst_wr", 134'(o_data_wr), 134'd0);
    check("rst_inport", 134'(ov_inport), 134'd0);
    check("rst_abort", 134'(ov_abort_cnt), 134'd0);

    // Single ARP frame
    iv_req = 3'b001;
    cyc();
    check("arp_grant", 134'(ov_grant), 134'(3'b001));
    check("arp_inport", 134'(ov_inport), 134'(4'h3));
    drive(0, mk(2'b01, 4'h0), 1'b1);
    drive(0, mk(2'b11, 4'h0), 1'b1);
    drive(0, mk(2'b11, 4'h0), 1'b1);
    check("arp_grant_mid", 134'(ov_grant), 134'(3'b001));
    iv_req = 3'b000;
    drive(0, mk(2'b10, 4'h6), 1'b1);
    check("arp_grant_drop", 134'(ov_grant), 134'd0);
    cyc();
    check("arp_gap1_wr", 134'(o_data_wr), 134'd0);
    cyc();
    check("arp_gap2_wr", 134'(o_data_wr), 134'd0);

    // Fairness from a fresh pointer
    i_rst = 1'b1;
    cyc();
    i_rst = 1'b0;
    iv_req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_grant(n);
      check("fair_grant", 134'(ov_grant), 134'(fair_exp[k]));
      if (k > 0) check("fair_gap", 134'(n), 134'(G + 1));
      drive(fair_port[k], mk(2'b01, 4'h0), 1'b1);
      drive(fair_port[k], mk(2'b10, 4'(k)), 1'b1);
      check("fair_grant_drop", 134'(ov_grant), 134'd0);
    end

    // Stall in TRANS on PTP
    iv_req = 3'b010;
    wait_grant(n);
    check("stall_grant", 134'(ov_grant), 134'(3'b010));
    check("stall_gap", 134'(n), 134'(G + 1));
    check("stall_inport", 134'(ov_inport), 134'(4'h5));
    drive(1, mk(2'b01, 4'h0), 1'b1);
    repeat (TO - 1) cyc();
    check("stall_abort_early", 134'(ov_abort_cnt), 134'd0);
    check("stall_grant_held", 134'(ov_grant), 134'(3'b010));
    exp_q.push_back(FORCED);
    cyc();
    check("stall_grant_drop", 134'(ov_grant), 134'd0);
    check("stall_abort", 134'(ov_abort_cnt), 134'd1);

    // Next PTP request after the gap, then withdrawn before a head
    wait_grant(n);
    check("ptp2_grant", 134'(ov_grant), 134'(3'b010));
    check("ptp2_gap", 134'(n), 134'(G + 1));
    iv_data0 = mk(2'b01, 4'h0);
    iv_data2 = mk(2'b01, 4'h0);
    i_data0_wr = 1'b1;
    i_data2_wr = 1'b1;
    cyc();
    check("deassert_grant_held", 134'(ov_grant), 134'(3'b010));
    iv_req = 3'b000;
    cyc();
    i_data0_wr = 1'b0;
    i_data2_wr = 1'b0;
    check("deassert_grant", 134'(ov_grant), 134'd0);
    check("deassert_abort", 134'(ov_abort_cnt), 134'd1);

    // Head inside an NMAC frame
    iv_req = 3'b100;
    wait_grant(n);
    check("nmac_grant", 134'(ov_grant), 134'(3'b100));
    check("nmac_inport", 134'(ov_inport), 134'(4'h9));
    drive(2, mk(2'b11, 4'h0), 1'b0);
    drive(2, mk(2'b01, 4'h0), 1'b1);
    drive(2, mk(2'b11, 4'h0), 1'b1);
    iv_req = 3'b000;
    exp_q.push_back(FORCED);
    drive(2, mk(2'b01, 4'h0), 1'b0);
    check("nmac_grant_drop", 134'(ov_grant), 134'd0);
    check("nmac_abort", 134'(ov_abort_cnt), 134'd2);

    // Reset mid-frame
    iv_req = 3'b001;
    wait_grant(n);
    check("rmid_grant", 134'(ov_grant), 134'(3'b001));
    drive(0, mk(2'b01, 4'h0), 1'b1);
    iv_data0 = mk(2'b11, 4'h0);
    i_data0_wr = 1'b1;
    @(negedge i_clk);
    #1 i_rst = 1'b1;
    #1;
    check("rmid_grant_rst", 134'(ov_grant), 134'd0);
    check("rmid_data_rst", ov_data, 134'd0);
    check("rmid_wr_rst", 134'(o_data_wr), 134'd0);
    check("rmid_inport_rst", 134'(ov_inport), 134'd0);
    check("rmid_abort_rst", 134'(ov_abort_cnt), 134'd0);
    i_data0_wr = 1'b0;
    iv_req = 3'b000;
    cyc();
    cyc();
    i_rst = 1'b0;
    iv_req = 3'b111;
    wait_grant(n);
    check("rmid_first_grant", 134'(ov_grant), 134'(3'b001));
    iv_req = 3'b000;

    repeat (4) cyc();
    check("sb_drained", 134'(exp_q.size()), 134'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
